// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit 7-segment driver with guard time, blanking and frame-synchronous updates
module seg7_scan_driver #(
  parameter int N_DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD = 2,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic POL = ACTIVE_LOW != 0;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [PW-1:0] p;
  logic [IW-1:0] idx;
  logic [4*N_DIGITS-1:0] act_v, pend_v;
  logic [N_DIGITS-1:0] act_d, pend_d, blank;
  logic pend_f, wrap, last, lead;
  logic [3:0] nib;
  assign wrap = p == PW'(REFRESH_DIV - 1);
  assign last = wrap && idx == IW'(N_DIGITS - 1);
  assign nib = act_v[4*idx +: 4];
  // a digit is blank while it and every digit above it is zero; digit 0 always shows
  always_comb begin
    blank = '0;
    lead = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lead = lead && act_v[4*i +: 4] == 4'd0;
      blank[i] = BLANK_LEADING != 0 && lead && i != 0;
    end
  end
  // scan counters, double buffer swap at frame end, and registered pin drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
      idx <= '0;
      act_v <= '0;
      act_d <= '0;
      pend_v <= '0;
      pend_d <= '0;
      pend_f <= 1'b0;
      frame_done <= 1'b0;
      seg <= {7{POL}};
      dp <= POL;
      an <= {N_DIGITS{POL}};
    end else begin
      pend_v <= load ? value : pend_v;
      pend_d <= load ? dp_in : pend_d;
      pend_f <= load || (pend_f && !(enable && last));
      act_v <= enable && last && pend_f ? pend_v : act_v;
      act_d <= enable && last && pend_f ? pend_d : act_d;
      p <= !enable || wrap ? '0 : p + 1'b1;
      idx <= !enable || last ? '0 : wrap ? idx + 1'b1 : idx;
      frame_done <= enable && last;
      seg <= {7{POL}} ^ (enable && !blank[idx] ? HEX[nib] : 7'd0);
      dp <= POL ^ (enable && act_d[idx]);
      an <= {N_DIGITS{POL}} ^ (enable && int'(p) >= GUARD ? N_DIGITS'(1) << idx : '0);
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed stimulus with a frame-time model checked every cycle
module tb_seg7_scan_driver;
  localparam int ND = 4, RD = 8, G = 1;
  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic clk = 0, rst_n = 1, enable = 0, load = 0;
  logic [15:0] value = 0;
  logic [3:0] dp_in = 0;
  logic [6:0] seg;
  logic dp, frame_done;
  logic [3:0] an;
  int total = 0, bad = 0;
  int t;
  logic [15:0] act_v, pend_v;
  logic [3:0] act_d, pend_d, e_an;
  logic pend_f, e_dp, e_fd;
  logic [6:0] e_seg;

  seg7_scan_driver #(.N_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(G), .ACTIVE_LOW(1), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done));

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, a, e, $time);
    end
  endtask

  // model: position in frame follows from cycles elapsed since enable, not from scan counters
  always @(posedge clk or negedge rst_n) begin
    int slot, ph;
    logic [15:0] hi;
    logic fd;
    if (!rst_n) begin
      t <= 0;
      act_v <= 0; act_d <= 0; pend_v <= 0; pend_d <= 0; pend_f <= 0;
      e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1; e_fd <= 0;
    end else begin
      fd = 0;
      if (!enable) begin
        t <= 0;
        e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1; e_fd <= 0;
      end else begin
        slot = (t / RD) % ND;
        ph = t % RD;
        hi = act_v >> (4 * slot);
        fd = ph == RD - 1 && slot == ND - 1;
        e_seg <= (slot != 0 && hi == 0) ? 7'h7F : ~HEX[hi[3:0]];
        e_dp <= ~act_d[slot];
        e_an <= ph < G ? 4'hF : ~(4'(1) << slot);
        e_fd <= fd;
        t <= t + 1;
        if (fd && pend_f) begin
          act_v <= pend_v;
          act_d <= pend_d;
        end
      end
      if (load) begin
        pend_v <= value; pend_d <= dp_in; pend_f <= 1;
      end else if (fd) pend_f <= 0;
    end
  end

  always @(negedge clk) begin
    check("seg", seg, e_seg);
    check("dp", dp, e_dp);
    check("an", an, e_an);
    check("frame_done", frame_done, e_fd);
    check("an_single", $countones(~an) <= 1, 1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fd(int bound);
    int n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < bound);
    check("wait_fd", frame_done, 1);
  endtask

  initial begin
    #1 rst_n = 0;
    #1;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1);
    @(posedge clk); #2;
    rst_n = 1; enable = 1; load = 1; value = 16'h1234; dp_in = 0;
    step(); load = 0;
    check("t1_guard_an", an, 4'hF);
    check("t1_pre_seg", seg, 7'h40);
    wait_fd(40);
    step();
    check("t1_d0_guard_an", an, 4'hF);
    check("t1_d0_seg_g", seg, 7'h19);
    step();
    check("t1_d0_an", an, 4'hE);
    check("t1_d0_seg", seg, 7'h19);
    repeat (24) step();
    check("t1_d3_an", an, 4'h7);
    check("t1_d3_seg", seg, 7'h79);
    repeat (5) step();
    check("t1_fd_low", frame_done, 0);
    step();
    check("t1_fd_period", frame_done, 1);
    value = 16'h0050; dp_in = 4'b1000; load = 1;
    step(); load = 0;
    wait_fd(40);
    step(); step();
    check("t2_d0_seg", seg, 7'h40);
    check("t2_d0_dp", dp, 1);
    repeat (8) step();
    check("t2_d1_seg", seg, 7'h12);
    repeat (8) step();
    check("t2_d2_seg", seg, 7'h7F);
    repeat (8) step();
    check("t2_d3_seg", seg, 7'h7F);
    check("t2_d3_dp", dp, 0);
    check("t2_d3_an", an, 4'h7);
    value = 16'h0000; dp_in = 0; load = 1;
    step(); load = 0;
    wait_fd(40);
    step(); step();
    check("t3_d0_seg", seg, 7'h40);
    repeat (8) step();
    check("t3_d1_seg", seg, 7'h7F);
    check("t3_d1_an", an, 4'hD);
    value = 16'h1234; load = 1;
    step(); load = 0;
    wait_fd(40);
    repeat (10) step();
    value = 16'hABCD; load = 1;
    step(); load = 0;
    repeat (7) step();
    value = 16'hFFFF; load = 1;
    step(); load = 0;
    repeat (8) step();
    check("t5_old_d3", seg, 7'h79);
    wait_fd(40);
    step(); step();
    check("t5_new_d0", seg, 7'h0E);
    repeat (24) step();
    check("t5_new_d3", seg, 7'h0E);
    wait_fd(40);
    repeat (20) step();
    #1 rst_n = 0;
    #1;
    check("t6_rst_an", an, 4'hF);
    check("t6_rst_seg", seg, 7'h7F);
    check("t6_rst_dp", dp, 1);
    @(posedge clk); #2;
    rst_n = 1;
    repeat (3) step();
    enable = 0;
    repeat (5) begin
      step();
      check("t6_off_an", an, 4'hF);
      check("t6_off_fd", frame_done, 0);
    end
    enable = 1;
    step();
    check("t6_re_guard", an, 4'hF);
    step();
    check("t6_re_an", an, 4'hE);
    check("t6_re_seg", seg, 7'h40);
    repeat (40) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display bank. Generalises the single-digit hex decoder.
- Adds the following:
  - parametrised digit count
  - refresh prescaler and digit scanning
  - anti-ghosting guard time
  - leading-zero blanking
  - per-digit decimal points
  - tear-free double-buffered value updates at frame boundaries
- Sits between the datapath (value source) and the board's segment/anode pins.

Parameters:
N_DIGITS, 4, number of digits scanned; ≥1
REFRESH_DIV, 50000, clock cycles per digit slot; ≥2
GUARD, 2, cycles at start of each slot with all anodes off; 0 ≤ GUARD < REFRESH_DIV
ACTIVE_LOW, 1, 1: seg/dp/an driven low = on; 0: high = on
BLANK_LEADING, 1, 1: suppress leading zero digits

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  1: scanning runs; 0: display dark, scan state cleared
load  in  1  capture value/dp_in into pending buffer this cycle
value  in  4*N_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) = digit i, digit 0 = least significant/rightmost
dp_in  in  N_DIGITS  decimal point per digit, 1 = lit
seg  out  7  segments, seg[0]=a … seg[6]=g, polarity per ACTIVE_LOW
dp  out  1  decimal point of the selected digit
an  out  N_DIGITS  digit select, one-hot (active level) or all inactive
frame_done  out  1  one-cycle pulse when a full scan of all digits completes

Behaviour:
- Reset (rst_n=0, async) clears:
  - prescaler p, digit index idx, active and pending buffers, pending flag, frame_done
  - an = all inactive; seg = all off; dp = off (inactive level per ACTIVE_LOW)
- Reset applies on rst_n fall regardless of clock, including mid-frame.
- Decoding is active-high gfedcba, then inverted if ACTIVE_LOW:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Prescaler:
  - When enable=1, p counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, idx advances 0 → 1 → … → N_DIGITS-1 → 0.
- Frame boundary is the cycle with p=REFRESH_DIV-1 and idx=N_DIGITS-1. On that edge:
  - frame_done pulses 1 for exactly one cycle.
  - If the pending flag is set, active ← pending and the flag clears.
- Buffering:
  - load=1 copies value/dp_in into pending and sets the flag.
  - Repeated loads before a boundary overwrite pending; last one wins.
  - A load in the same cycle as the boundary goes to pending and is applied at the next boundary. The active buffer takes the older pending contents.
  - Loads are accepted while enable=0.
- Outputs are registered: the state (idx, p) in cycle t is reflected on seg/dp/an in cycle t+1.
- For p < GUARD: an all inactive; seg/dp still driven with digit idx.
- For p ≥ GUARD: an[idx] active, all others inactive.
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit i is blank if its nibble and every higher-index nibble are 0.
  - Digit 0 is never blanked.
  - A blank digit drives seg all off.
  - dp is never blanked (dp_in[i] shown).
- enable=0:
  - Within one cycle p=0, idx=0, an all inactive, seg/dp off, frame_done=0.
  - Re-enabling starts at digit 0, p=0.
- N_DIGITS=1: idx stays 0; a frame boundary occurs every REFRESH_DIV cycles.
- frame_done period with enable held high = N_DIGITS*REFRESH_DIV cycles.

Test Plan:
All tests use N_DIGITS=4, REFRESH_DIV=8, GUARD=1, ACTIVE_LOW=1, BLANK_LEADING=1.
1. Reset, enable=1, load value=16'h1234, dp_in=0 in cycle 0 → display stays blank-decoded 0 until first frame_done (cycle 31 edge). Then:
   - digit 0 slot: an=4'b1110, seg=7'h19 ('4')
   - digit 3 slot: an=4'b0111, seg=7'h79 ('1')
   - frame_done every 32 cycles
2. value=16'h0050, dp_in=4'b1000:
   - digits 3 and 2: seg=7'h7F (blank); digit 3 dp=0 (lit)
   - digit 1: seg=7'h12 ('5')
   - digit 0: seg=7'h40 ('0')
3. value=16'h0000 → digits 3..1 seg=7'h7F; digit 0 seg=7'h40; an still scans all four.
4. Guard/anti-ghost → for each slot, the first output cycle has an=4'b1111, the next 7 cycles have one-hot-low an; never two anodes active.
5. Mid-frame load: showing 16'h1234, load 16'hABCD while idx=1, then 16'hFFFF while idx=2 → current frame unchanged; after boundary all digits seg=7'h0E ('F'), and ABCD is never displayed.
6. Control/reset interruptions:
   - rst_n low at idx=2, p=4 (between edges) → an=4'b1111, seg=7'h7F, dp=1 immediately.
   - enable low for 5 cycles → an=4'b1111, no frame_done; after re-enable, first active anode is 4'b1110 after GUARD.
